// File: rtl/f_fetch_unit.sv
// F-stage fetch unit: owns F_PC and the F/D register, drives a request/response
// instruction-memory port, and parks one early response while D is frozen.
module f_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] NPC,
  input  logic        D_stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] F_PC,
  output logic [31:0] D_PC,
  output logic [31:0] D_instr,
  output logic        fetch_busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] hold_buf;
  logic        advance;
  logic        capture;

  // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    advance    = 1'b0;
    capture    = 1'b0;
    unique case (state)
      S_IDLE: state_next = S_WAIT;
      S_WAIT: begin
        if (imem_rvalid) begin
          if (D_stall) begin
            capture    = 1'b1;
            state_next = S_HOLD;
          end else begin
            advance    = 1'b1;
            state_next = S_WAIT;
          end
        end
      end
      S_HOLD: begin
        if (!D_stall) begin
          advance    = 1'b1;
          state_next = S_WAIT;
        end
      end
      default: state_next = S_IDLE;
    endcase

    // The next fetch goes out in the advance cycle: NPC is already derived from
    // the instruction leaving for D, so no extra request cycle is needed.
    imem_req   = !reset && ((state == S_IDLE) || advance);
    imem_addr  = (state == S_IDLE) ? F_PC : NPC;
    // Depends on state and imem_rvalid only, so the hazard unit can fold it into D_stall.
    fetch_busy = (state == S_IDLE) || ((state == S_WAIT) && !imem_rvalid);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      F_PC     <= RESET_PC;
      D_PC     <= 32'h0;
      D_instr  <= 32'h0;
      hold_buf <= 32'h0;
    end else begin
      state <= state_next;
      if (capture) begin
        hold_buf <= imem_rdata;
      end
      if (advance) begin
        D_PC    <= F_PC;
        D_instr <= (state == S_WAIT) ? imem_rdata : hold_buf;
        F_PC    <= NPC;
      end
    end
  end

endmodule

// File: tb/tb_f_fetch_unit.sv
// Bench for f_fetch_unit: variable-latency memory model, a transaction-level
// fetch model checked every cycle, and directed scenarios with literal expectations.
module tb_f_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] NPC = 32'h0;
  logic        ext_stall = 1'b0;
  logic        d_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] F_PC;
  logic [31:0] D_PC;
  logic [31:0] D_instr;
  logic        fetch_busy;

  // Hazard unit folds fetch_busy into the D freeze.
  assign d_stall = ext_stall | fetch_busy;

  f_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .reset      (reset),
    .NPC        (NPC),
    .D_stall    (d_stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .F_PC       (F_PC),
    .D_PC       (D_PC),
    .D_instr    (D_instr),
    .fetch_busy (fetch_busy)
  );

  always #5 clk = ~clk;

  // Knobs take effect 1 time unit after the next rising edge.
  bit          k_reset = 1'b1;
  bit          k_stall = 1'b0;
  bit          k_inject = 1'b0;
  bit          k_npc_en = 1'b0;
  logic [31:0] k_npc = 32'h0;
  int          k_lat = 1;
  logic [31:0] special_addr = 32'h0000_0001;

  int          mem_cnt = 0;
  logic [31:0] mem_addr = 32'h0;

  // Model: an in-flight request flag and an already-delivered instruction buffer.
  logic [31:0] m_f_pc = RESET_PC;
  logic [31:0] m_d_pc = 32'h0;
  logic [31:0] m_d_instr = 32'h0;
  logic [31:0] m_buf = 32'h0;
  bit          m_out = 1'b0;
  bit          m_have = 1'b0;
  bit          m_valid = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a == special_addr) ? 32'h2401_0001 : (a ^ 32'hFFFF_0000);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    bit          ready;
    bit          adv;
    bit          exp_req;
    logic [31:0] word_now;
    @(posedge clk);
    #1;
    reset     = k_reset;
    ext_stall = k_stall;
    if (reset) begin
      mem_cnt     = 0;
      imem_rvalid = k_inject;
      imem_rdata  = 32'hDEAD_BEEF;
    end else if (mem_cnt > 0) begin
      mem_cnt--;
      imem_rvalid = (mem_cnt == 0);
      imem_rdata  = (mem_cnt == 0) ? word(mem_addr) : 32'hBAD0_0BAD;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hBAD0_0BAD;
    end
    NPC = k_npc_en ? k_npc : m_f_pc + 32'd4;
    #1;
    ready    = m_have || (m_out && imem_rvalid);
    word_now = m_have ? m_buf : imem_rdata;
    adv      = !reset && ready && !ext_stall;
    exp_req  = !reset && (adv || (!m_out && !m_have));
    if (m_valid) begin
      check("imem_req", imem_req, exp_req);
      if (exp_req) check("imem_addr", imem_addr, adv ? NPC : m_f_pc);
      check("fetch_busy", fetch_busy, !ready);
      check("F_PC", F_PC, m_f_pc);
      check("D_PC", D_PC, m_d_pc);
      check("D_instr", D_instr, m_d_instr);
    end
    if (imem_req && !reset) begin
      mem_addr = imem_addr;
      mem_cnt  = k_lat;
    end
    if (reset) begin
      m_f_pc = RESET_PC; m_d_pc = 32'h0; m_d_instr = 32'h0; m_buf = 32'h0;
      m_out = 1'b0; m_have = 1'b0; m_valid = 1'b1;
    end else if (adv) begin
      m_d_pc = m_f_pc; m_d_instr = word_now; m_f_pc = NPC;
      m_out = 1'b1; m_have = 1'b0;
    end else if (ready) begin
      m_have = 1'b1; m_buf = word_now; m_out = 1'b0;
    end else if (!m_out && !m_have) begin
      m_out = 1'b1;
    end
  endtask

  // Counts busy cycles until D_PC changes, within a bounded window.
  task automatic count_busy(output int busy_cnt, output bit ok);
    logic [31:0] last;
    last     = D_PC;
    busy_cnt = 0;
    ok       = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (D_PC !== last) begin
        ok = 1'b1;
        break;
      end
      if (fetch_busy) busy_cnt++;
      tick();
    end
  endtask

  task automatic do_reset();
    k_reset = 1'b1;
    tick();
    tick();
    k_reset = 1'b0;
  endtask

  initial begin
    int          cnt;
    bit          ok;
    logic [31:0] prev;
    logic [31:0] sp;

    // Reset release and 1-cycle memory streaming.
    do_reset();
    tick();
    check("cyc1 imem_req", imem_req, 1'b1);
    check("cyc1 imem_addr", imem_addr, 32'h0000_3000);
    check("cyc1 F_PC", F_PC, 32'h0000_3000);
    check("cyc1 D_instr", D_instr, 32'h0);
    check("cyc1 fetch_busy", fetch_busy, 1'b1);
    tick();
    check("cyc2 imem_addr", imem_addr, 32'h0000_3004);
    tick();
    check("cyc3 D_PC", D_PC, 32'h0000_3000);
    check("cyc3 D_instr", D_instr, 32'hFFFF_3000);
    check("cyc3 imem_req", imem_req, 1'b1);
    tick();
    check("cyc4 D_PC", D_PC, 32'h0000_3004);
    check("cyc4 imem_req", imem_req, 1'b1);
    tick();
    check("cyc5 D_PC", D_PC, 32'h0000_3008);

    // 3-cycle latency: two busy cycles per instruction.
    k_lat = 3;
    tick();
    count_busy(cnt, ok);
    check("lat3 sync", ok, 1'b1);
    prev = D_PC;
    count_busy(cnt, ok);
    check("lat3 no timeout", ok, 1'b1);
    check("lat3 busy cycles", cnt, 2);
    check("lat3 D_PC step", D_PC - prev, 32'd4);

    // Response under a 2-cycle stall goes to the hold buffer, no re-request.
    k_lat = 1;
    repeat (5) tick();
    sp           = m_f_pc;
    special_addr = sp;
    k_stall      = 1'b1;
    tick();
    check("hold a imem_req", imem_req, 1'b0);
    check("hold a fetch_busy", fetch_busy, 1'b0);
    tick();
    check("hold b imem_req", imem_req, 1'b0);
    check("hold b fetch_busy", fetch_busy, 1'b0);
    k_stall = 1'b0;
    tick();
    check("hold c imem_req", imem_req, 1'b1);
    check("hold c imem_addr", imem_addr, sp + 32'd4);
    tick();
    check("hold d D_instr", D_instr, 32'h2401_0001);
    check("hold d D_PC", D_PC, sp);
    special_addr = 32'h0000_0001;

    // Reset while waiting on a 3-cycle fetch, with stale rvalid during reset.
    k_lat = 3;
    repeat (3) tick();
    k_inject = 1'b1;
    do_reset();
    k_inject = 1'b0;
    tick();
    check("rst c1 imem_req", imem_req, 1'b1);
    check("rst c1 imem_addr", imem_addr, 32'h0000_3000);
    check("rst c1 D_instr", D_instr, 32'h0);
    check("rst c1 D_PC", D_PC, 32'h0);
    tick();
    check("rst c2 fetch_busy", fetch_busy, 1'b1);
    tick();
    check("rst c3 D_instr", D_instr, 32'h0);
    tick();
    check("rst c4 fetch_busy", fetch_busy, 1'b0);
    tick();
    check("rst c5 D_instr", D_instr, 32'hFFFF_3000);

    // Taken branch in D at 0x3000: slot at 0x3004 still enters D.
    k_lat = 1;
    do_reset();
    tick();
    tick();
    k_npc_en = 1'b1;
    k_npc    = 32'h0000_3010;
    tick();
    check("br D_PC", D_PC, 32'h0000_3000);
    check("br imem_req", imem_req, 1'b1);
    check("br imem_addr", imem_addr, 32'h0000_3010);
    k_npc_en = 1'b0;
    tick();
    check("slot D_PC", D_PC, 32'h0000_3004);
    check("slot F_PC", F_PC, 32'h0000_3010);
    tick();
    check("target D_PC", D_PC, 32'h0000_3010);

    // PC wrap-around.
    k_npc_en = 1'b1;
    k_npc    = 32'hFFFF_FFFC;
    tick();
    k_npc_en = 1'b0;
    tick();
    check("wrap F_PC top", F_PC, 32'hFFFF_FFFC);
    tick();
    check("wrap F_PC zero", F_PC, 32'h0);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
